// File: rtl/mont_pkg.sv
// Shared constants and state encoding for the Montgomery datapath blocks.
package mont_pkg;

  localparam int unsigned WORD_W  = 32;  // operand / modulus width
  localparam int unsigned ACC_W   = 34;  // accumulator width, holds S < 2N
  localparam int unsigned LEN_W   = 8;   // width of the len (log2 R) field
  localparam int unsigned MAX_LEN = 32;  // largest legal len

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/mont_mul_if.sv
// Request/response bundle between a Montgomery multiplier and its user.
interface mont_mul_if;
  import mont_pkg::*;

  logic                mm_start;
  logic [LEN_W-1:0]    len;
  logic [WORD_W-1:0]   a;
  logic [WORD_W-1:0]   b;
  logic [WORD_W-1:0]   modulus;
  logic                mm_end;
  logic [WORD_W-1:0]   mm_out;

  // Requester side
  modport master (
    output mm_start, len, a, b, modulus,
    input  mm_end, mm_out
  );

  // Multiplier side
  modport slave (
    input  mm_start, len, a, b, modulus,
    output mm_end, mm_out
  );

endinterface

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: S_next = (S + a_bit*b [+ N if odd]) / 2.
module mont_step
  import mont_pkg::*;
(
  input  logic [ACC_W-1:0]  s_i,
  input  logic              a_bit_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic [WORD_W-1:0] n_i,
  output logic [ACC_W-1:0]  s_next_o
);

  // One bit wider than S so S + b + N (< 4N) never wraps
  logic [ACC_W:0] t_add;
  logic [ACC_W:0] t_odd;

  // Conditional add of b, then make the sum even by adding N, then halve
  always_comb begin
    t_add    = {1'b0, s_i} + (a_bit_i ? {{(ACC_W + 1 - WORD_W){1'b0}}, b_i} : '0);
    t_odd    = t_add[0] ? (t_add + {{(ACC_W + 1 - WORD_W){1'b0}}, n_i}) : t_add;
    s_next_o = t_odd[ACC_W:1];
  end

endmodule

// File: rtl/mont_mul.sv
// Radix-2 Montgomery multiplier: mm_out = a * b * 2^-len mod modulus, one bit per cycle.
module mont_mul
  import mont_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  mont_mul_if.slave bus
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic [WORD_W-1:0] n_q, n_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  s_q, s_d;
  logic [WORD_W-1:0] out_q, out_d;

  logic [ACC_W-1:0]  s_next;
  logic [ACC_W-1:0]  n_ext;
  logic              len_bad;

  assign n_ext   = {{(ACC_W - WORD_W){1'b0}}, n_q};
  assign len_bad = (bus.len == '0) || (bus.len > LEN_W'(MAX_LEN));

  mont_step u_step (
    .s_i      (s_q),
    .a_bit_i  (a_q[0]),
    .b_i      (b_q),
    .n_i      (n_q),
    .s_next_o (s_next)
  );

  // Next-state logic: operand latch, bit-serial iteration, final reduction
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    out_d   = out_q;

    unique case (state_q)
      StIdle: begin
        if (bus.mm_start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          n_d     = bus.modulus;
          cnt_d   = bus.len;
          s_d     = '0;
          out_d   = '0;
          state_d = len_bad ? StDone : StCalc;
        end
      end
      StCalc: begin
        s_d   = s_next;
        a_d   = a_q >> 1;
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        // S < 2N, so a single conditional subtract lands in [0, N)
        if (s_q >= n_ext) begin
          out_d = WORD_W'(s_q - n_ext);
        end else begin
          out_d = s_q[WORD_W-1:0];
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      out_q   <= out_d;
    end
  end

  assign bus.mm_end = (state_q == StDone);
  assign bus.mm_out = out_q;

endmodule

// File: tb/tb_mont_mul.sv
// Self-checking bench for mont_mul: directed table, corner sequences, random vs. modular model.
module tb_mont_mul;

  logic clk;
  logic rst;

  mont_mul_if bus ();

  mont_mul dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_pass;

  typedef struct {
    string       name;
    logic [7:0]  len;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] n;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // a * b * 2^-len mod n, by repeated multiplication with the inverse of 2
  function automatic logic [31:0] ref_mont(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] n, input int len);
    longint unsigned nn;
    longint unsigned r;
    longint unsigned inv2;
    nn   = longint'(n);
    inv2 = (nn + 1) / 2;
    r    = (longint'(a) * longint'(b)) % nn;
    for (int i = 0; i < len; i++) begin
      r = (r * inv2) % nn;
    end
    return r[31:0];
  endfunction

  // Issue one start, measure latency, check result, pulse width and hold
  task automatic run_op(input string nm, input logic [7:0] len, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] n, input logic [31:0] exp);
    int cyc;
    int exp_lat;
    logic [31:0] res;
    exp_lat = (len == 0 || len > 32) ? 1 : int'(len) + 2;
    bus.len      = len;
    bus.a        = a;
    bus.b        = b;
    bus.modulus  = n;
    bus.mm_start = 1'b1;
    step();
    bus.mm_start = 1'b0;
    // Scramble inputs: the block must use latched copies
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.modulus  = $urandom;
    bus.len      = 8'($urandom);
    check({nm, "_out_cleared"}, bus.mm_out, 32'd0);
    cyc = 1;
    while (!bus.mm_end && cyc < 100) begin
      step();
      cyc++;
    end
    check({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
    res = bus.mm_out;
    check({nm, "_result"}, res, exp);
    step();
    check({nm, "_end_one_cycle"}, {31'd0, bus.mm_end}, 32'd0);
    check({nm, "_hold"}, bus.mm_out, exp);
  endtask

  initial begin
    int ends;
    int end_cyc;
    int bad_out;
    int cyc;
    logic [31:0] end_out;
    logic [7:0]  rlen;
    logic [31:0] rn;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] mask;

    n_total = 0;
    n_pass  = 0;

    vecs[0] = '{"small",      8'd4,  32'd5,        32'd7,        32'd13,        32'd3};
    vecs[1] = '{"roundtrip",  8'd4,  32'd2,        32'd1,        32'd13,        32'd5};
    vecs[2] = '{"fullwidth",  8'd32, 32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFB, 32'hCCCCCCC9};
    vecs[3] = '{"len0",       8'd0,  32'd5,        32'd7,        32'd13,        32'd0};
    vecs[4] = '{"after_len0", 8'd4,  32'd5,        32'd7,        32'd13,        32'd3};
    vecs[5] = '{"len40",      8'd40, 32'd5,        32'd7,        32'd13,        32'd0};
    vecs[6] = '{"after_len40", 8'd4, 32'd2,        32'd1,        32'd13,        32'd5};

    bus.mm_start = 1'b0;
    bus.len      = 8'd0;
    bus.a        = '0;
    bus.b        = '0;
    bus.modulus  = '0;
    rst          = 1'b1;
    step();
    step();
    check("reset_mm_end", {31'd0, bus.mm_end}, 32'd0);
    check("reset_mm_out", bus.mm_out, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].name, vecs[i].len, vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].exp);
    end

    // Start while busy: second request at cycle 3 must be ignored
    bus.len = 8'd4; bus.a = 32'd5; bus.b = 32'd7; bus.modulus = 32'd13;
    bus.mm_start = 1'b1;
    step();
    bus.mm_start = 1'b0;
    step();
    step();
    bus.len = 8'd2; bus.a = 32'd1; bus.b = 32'd2; bus.modulus = 32'd3;
    bus.mm_start = 1'b1;
    cyc = 3;
    ends = 0; end_cyc = 0; end_out = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      bus.mm_start = 1'b0;
      cyc++;
      if (bus.mm_end) begin
        ends++;
        end_cyc = cyc;
        end_out = bus.mm_out;
      end
    end
    check("busy_end_count", 32'(ends), 32'd1);
    check("busy_end_cycle", 32'(end_cyc), 32'd6);
    check("busy_result", end_out, 32'd3);

    // Reset at cycle 2 with a simultaneous start: both operation and start dropped
    bus.len = 8'd4; bus.a = 32'd5; bus.b = 32'd7; bus.modulus = 32'd13;
    bus.mm_start = 1'b1;
    step();
    bus.mm_start = 1'b0;
    step();
    rst = 1'b1;
    bus.mm_start = 1'b1;
    step();
    rst = 1'b0;
    bus.mm_start = 1'b0;
    ends = 0; bad_out = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.mm_end) ends++;
      if (bus.mm_out != 32'd0) bad_out++;
      step();
    end
    check("rst_no_end", 32'(ends), 32'd0);
    check("rst_out_zero", 32'(bad_out), 32'd0);
    run_op("after_rst", 8'd4, 32'd5, 32'd7, 32'd13, 32'd3);

    // Random legal operands against the modular-arithmetic model
    for (int k = 0; k < 25; k++) begin
      rlen = 8'($urandom_range(2, 32));
      mask = (rlen == 8'd32) ? 32'hFFFFFFFF : ((32'd1 << rlen) - 32'd1);
      rn   = ($urandom & mask) | 32'd1;
      if (rn < 32'd3) rn = 32'd3;
      ra   = $urandom % rn;
      rb   = $urandom % rn;
      run_op($sformatf("rand%0d", k), rlen, ra, rb, rn, ref_mont(ra, rb, rn, int'(rlen)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
